rv_mem_resp: RTL and testbench

RV_MEM_RESP -- requirements
Module: rv_mem_resp

---
 rtl/rv_mem_resp_pkg.sv | 16 +
 rtl/rv_mem_array.sv | 21 ++
 rtl/rv_mem_resp.sv | 94 +++++++++
 tb/tb_rv_mem_resp.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_resp_pkg.sv
// Shared types and constants for the rv_mem_resp latency-modelled memory responder.
package rv_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    // Wide enough for LATENCY-2 with LATENCY up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/rv_mem_array.sv
// Word storage: synchronous write, combinational read, contents never reset.
module rv_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/rv_mem_resp.sv
// Single-outstanding memory responder: accepts a request in IDLE and answers
// with a one-cycle ready pulse exactly LATENCY cycles later.
module rv_mem_resp
    import rv_mem_resp_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        memrw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             acc, bad_addr, we, show_rd;
    logic             rw_q, err_q;
    logic [AW-1:0]    idx_q;
    logic [31:0]      wdata_q, rdata_q, mem_rdata;

    assign acc      = (state == IDLE) && req;
    assign bad_addr = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (req) begin
                if (LATENCY == 1) begin
                    state_nx = RESP;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = CNT_INIT;
                end
            end
            WAIT: if (cnt == '0) state_nx = RESP;
                  else           cnt_nx   = cnt - 1'b1;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rw_q    <= MEM_RD;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (acc) begin
                rw_q    <= memrw;
                err_q   <= bad_addr;
                idx_q   <= addr[AW+1:2];
                wdata_q <= wdata;
            end
            // Remember the last good load so rdata holds it outside RESP.
            if (show_rd) rdata_q <= mem_rdata;
        end
    end

    assign ready   = (state == RESP);
    assign busy    = (state != IDLE);
    assign err     = ready && err_q;
    assign show_rd = ready && (rw_q == MEM_RD) && !err_q;
    assign we      = ready && (rw_q == MEM_WR) && !err_q;
    assign rdata   = show_rd ? mem_rdata : rdata_q;

    rv_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_rv_mem_resp.sv
// Directed bench for rv_mem_resp: three instances (LATENCY 2, 1, 4) with a
// shared scoreboard of expected responses checked when ready fires.
module tb_rv_mem_resp;

    localparam int LAT[3] = '{2, 1, 4};

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = '0, memrw = '0;
    logic [31:0] addr[3], wdata[3], rdata[3];
    logic [2:0]  ready, busy, err;

    int          total = 0, bad = 0, cyc = 0;
    exp_t        sb[$];
    logic [31:0] last_rd[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv_mem_resp #(.DEPTH(256), .LATENCY(LAT[0])) u_l2 (
        .clk(clk), .rst(rst), .req(req[0]), .memrw(memrw[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]), .err(err[0]));
    rv_mem_resp #(.DEPTH(256), .LATENCY(LAT[1])) u_l1 (
        .clk(clk), .rst(rst), .req(req[1]), .memrw(memrw[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]), .err(err[1]));
    rv_mem_resp #(.DEPTH(256), .LATENCY(LAT[2])) u_l4 (
        .clk(clk), .rst(rst), .req(req[2]), .memrw(memrw[2]), .addr(addr[2]),
        .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]), .busy(busy[2]), .err(err[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected rdata: a good read returns the word, anything else holds the last load.
    task automatic push(input int i, input logic rw, input logic [31:0] word,
                        input logic e, input int at);
        exp_t x;
        x.dut = i; x.err = e; x.cyc = at;
        if (rw == 1'b0 && !e) last_rd[i] = word;
        x.rdata = last_rd[i];
        sb.push_back(x);
    endtask

    task automatic drive(input int i, input logic rw, input logic [31:0] a, input logic [31:0] d);
        memrw[i] = rw; addr[i] = a; wdata[i] = d; req[i] = 1'b1;
    endtask

    // Single request: accepted this cycle, busy must be up the next cycle.
    task automatic go(input int i, input logic rw, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] word, input logic e);
        drive(i, rw, a, d);
        push(i, rw, word, e, cyc + LAT[i]);
        @(posedge clk); #1;
        req[i] = 1'b0;
        chk("busy_after_accept", 32'(busy[i]), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() > 0) begin
            chk("response_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                if (ready[i]) begin
                    chk("ready_expected", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("resp_dut", 32'(i), 32'(e.dut));
                        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
                        chk("err", 32'(err[i]), 32'(e.err));
                        chk("rdata", rdata[i], e.rdata);
                    end
                end else begin
                    chk("err_without_ready", 32'(err[i]), 32'd0);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; wdata[i] = '0; last_rd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_ready", 32'(ready[i]), 32'd0);
            chk("reset_busy", 32'(busy[i]), 32'd0);
            chk("reset_err", 32'(err[i]), 32'd0);
            chk("reset_rdata", rdata[i], 32'd0);
        end
        rst = 1'b1;

        // LATENCY=2 write then read, first accept right after reset release.
        go(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        wait_done();
        go(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        wait_done();

        // Misaligned and out-of-range accesses leave storage and rdata untouched.
        go(0, 1'b1, 32'h0, 32'h11112222, 32'h0, 1'b0);
        wait_done();
        go(0, 1'b1, 32'h12, 32'h99999999, 32'h0, 1'b1);
        wait_done();
        go(0, 1'b1, 32'h400, 32'h77777777, 32'h0, 1'b1);
        wait_done();
        go(0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
        wait_done();
        go(0, 1'b0, 32'h0, 32'h0, 32'h11112222, 1'b0);
        wait_done();

        // LATENCY=1 back-to-back with req held: ready every other cycle, busy low in IDLE.
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a, d;
            a = (k < 2) ? 32'h40 : 32'h44;
            d = 32'hCAFE0000 + 32'(k);
            if (k % 2 == 0) begin
                drive(1, 1'b1, a, d);
                push(1, 1'b1, 32'h0, 1'b0, cyc + 1);
            end else begin
                drive(1, 1'b0, a, 32'h0);
                push(1, 1'b0, 32'hCAFE0000 + 32'(k - 1), 1'b0, cyc + 1);
            end
            @(posedge clk); #1;
            chk("b2b_busy_resp", 32'(busy[1]), 32'd1);
            if (k == 3) req[1] = 1'b0;
            @(posedge clk); #1;
            chk("b2b_busy_idle", 32'(busy[1]), 32'd0);
        end
        wait_done();

        // LATENCY=4 last word; a req pulse during WAIT must be ignored.
        go(2, 1'b1, 32'h3FC, 32'hA5A5A5A5, 32'h0, 1'b0);
        wait_done();
        drive(2, 1'b0, 32'h3FC, 32'h0);
        push(2, 1'b0, 32'hA5A5A5A5, 1'b0, cyc + LAT[2]);
        @(posedge clk); #1;
        drive(2, 1'b1, 32'h3FC, 32'h0);
        @(posedge clk); #1;
        req[2] = 1'b0;
        wait_done();
        go(2, 1'b0, 32'h3FC, 32'h0, 32'hA5A5A5A5, 1'b0);
        wait_done();

        // Reset in WAIT aborts a write: no ready, old data survives.
        go(0, 1'b1, 32'h20, 32'h00000055, 32'h0, 1'b0);
        wait_done();
        drive(0, 1'b1, 32'h20, 32'h1234);
        @(posedge clk); #1;
        req[0] = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(ready[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_rdata", rdata[0], 32'd0);
        for (int i = 0; i < 3; i++) last_rd[i] = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        go(0, 1'b0, 32'h20, 32'h0, 32'h00000055, 1'b0);
        wait_done();

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
